ccu_snoop_arbiter: RTL and testbench

Shares one ACE snoop master interface (AC/CR/CD) between the CCU write-path and read-path snoop controllers. Round-robin arbitration on AC. Owner tracking in issue order, because the snooped cache returns CR and CD responses in AC order. Each CR response, and any following CD data burst, is routed back to the requester that issued the snoop. Sits between the snoop path's two snoop ports and the CCU's snoop fan-out logic.

---
 rtl/ccu_snoop_arbiter.sv | 215 +++++++++++++++++++++
 tb/tb_ccu_snoop_arbiter.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ccu_snoop_arbiter.sv
// rtl/ccu_snoop_arbiter.sv - two-requester ACE snoop arbiter with in-order CR/CD owner routing
module ccu_snoop_arbiter #(
  parameter int unsigned AddrWidth = 64,
  parameter int unsigned DataWidth = 64,
  parameter int unsigned MaxTrans  = 4
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  logic [1:0]                     slv_ac_valid_i,
  output logic [1:0]                     slv_ac_ready_o,
  input  logic [1:0][AddrWidth-1:0]      slv_ac_addr_i,
  input  logic [1:0][3:0]                slv_ac_snoop_i,
  input  logic [1:0][2:0]                slv_ac_prot_i,
  input  logic [1:0][1:0]                slv_domain_i,
  output logic [1:0]                     slv_cr_valid_o,
  input  logic [1:0]                     slv_cr_ready_i,
  output logic [1:0][4:0]                slv_cr_resp_o,
  output logic [1:0]                     slv_cd_valid_o,
  input  logic [1:0]                     slv_cd_ready_i,
  output logic [1:0][DataWidth-1:0]      slv_cd_data_o,
  output logic [1:0]                     slv_cd_last_o,
  output logic                           mst_ac_valid_o,
  input  logic                           mst_ac_ready_i,
  output logic [AddrWidth-1:0]           mst_ac_addr_o,
  output logic [3:0]                     mst_ac_snoop_o,
  output logic [2:0]                     mst_ac_prot_o,
  output logic [1:0]                     mst_domain_o,
  input  logic                           mst_cr_valid_i,
  output logic                           mst_cr_ready_o,
  input  logic [4:0]                     mst_cr_resp_i,
  input  logic                           mst_cd_valid_i,
  output logic                           mst_cd_ready_o,
  input  logic [DataWidth-1:0]           mst_cd_data_i,
  input  logic                           mst_cd_last_i
);

  localparam int unsigned PtrW = (MaxTrans > 1) ? $clog2(MaxTrans) : 1;
  localparam int unsigned CntW = $clog2(MaxTrans + 1);
  localparam logic [CntW-1:0] Full = CntW'(MaxTrans);

  // Arbitration state
  logic rr_q, rr_d;
  logic lock_q, lock_d;
  logic lock_gnt_q, lock_gnt_d;

  // Owner FIFOs: one owner bit per outstanding snoop / pending CD burst
  logic [MaxTrans-1:0] cr_mem_q, cr_mem_d;
  logic [PtrW-1:0]     cr_wptr_q, cr_wptr_d, cr_rptr_q, cr_rptr_d;
  logic [CntW-1:0]     cr_cnt_q, cr_cnt_d;
  logic [MaxTrans-1:0] cd_mem_q, cd_mem_d;
  logic [PtrW-1:0]     cd_wptr_q, cd_wptr_d, cd_rptr_q, cd_rptr_d;
  logic [CntW-1:0]     cd_cnt_q, cd_cnt_d;

  logic gnt, ac_req, ac_hs;
  logic cr_full, cr_empty, cd_full, cd_empty;
  logic cr_head, cd_head, cr_block, cr_hs, cd_hs;
  logic cr_push, cr_pop, cd_push, cd_pop;

  assign cr_full  = (cr_cnt_q == Full);
  assign cr_empty = (cr_cnt_q == '0);
  assign cd_full  = (cd_cnt_q == Full);
  assign cd_empty = (cd_cnt_q == '0);
  assign cr_head  = cr_mem_q[cr_rptr_q];
  assign cd_head  = cd_mem_q[cd_rptr_q];

  // Grant select: a held grant wins, then round-robin on contention, else the sole requester
  always_comb begin
    gnt = 1'b0;
    if (lock_q) begin
      gnt = lock_gnt_q;
    end else if (slv_ac_valid_i == 2'b11) begin
      gnt = rr_q;
    end else begin
      gnt = slv_ac_valid_i[1];
    end
  end

  assign ac_req = rst_ni & (|slv_ac_valid_i) & ~cr_full;
  assign ac_hs  = ac_req & mst_ac_ready_i;

  // AC forwarding: fields are muxed from the grant, zeroed when nothing is offered
  always_comb begin
    mst_ac_valid_o = ac_req;
    slv_ac_ready_o = 2'b00;
    mst_ac_addr_o  = '0;
    mst_ac_snoop_o = '0;
    mst_ac_prot_o  = '0;
    mst_domain_o   = '0;
    if (ac_req) begin
      slv_ac_ready_o[gnt] = mst_ac_ready_i;
      mst_ac_addr_o       = slv_ac_addr_i[gnt];
      mst_ac_snoop_o      = slv_ac_snoop_i[gnt];
      mst_ac_prot_o       = slv_ac_prot_i[gnt];
      mst_domain_o        = slv_domain_i[gnt];
    end
  end

  // CR routing: a DataTransfer response cannot complete until its CD owner slot exists
  always_comb begin
    cr_block       = mst_cr_resp_i[0] & cd_full;
    slv_cr_valid_o = 2'b00;
    mst_cr_ready_o = 1'b0;
    slv_cr_resp_o  = '0;
    if (rst_ni && !cr_empty) begin
      mst_cr_ready_o = slv_cr_ready_i[cr_head] & ~cr_block;
      if (!cr_block) begin
        slv_cr_valid_o[cr_head] = mst_cr_valid_i;
      end
      if (mst_cr_valid_i) begin
        slv_cr_resp_o = {2{mst_cr_resp_i}};
      end
    end
  end

  // CD routing: beats stall while no owner is known
  always_comb begin
    slv_cd_valid_o = 2'b00;
    mst_cd_ready_o = 1'b0;
    slv_cd_data_o  = '0;
    slv_cd_last_o  = 2'b00;
    if (rst_ni && !cd_empty) begin
      slv_cd_valid_o[cd_head] = mst_cd_valid_i;
      mst_cd_ready_o          = slv_cd_ready_i[cd_head];
      if (mst_cd_valid_i) begin
        slv_cd_data_o = {2{mst_cd_data_i}};
        slv_cd_last_o = {2{mst_cd_last_i}};
      end
    end
  end

  assign cr_hs   = mst_cr_valid_i & mst_cr_ready_o;
  assign cd_hs   = mst_cd_valid_i & mst_cd_ready_o;
  assign cr_push = ac_hs & ~cr_full;
  assign cr_pop  = cr_hs;
  assign cd_push = cr_hs & mst_cr_resp_i[0] & ~cd_full;
  assign cd_pop  = cd_hs & mst_cd_last_i;

  // Next state for rr pointer, grant lock and both owner FIFOs
  always_comb begin
    rr_d       = rr_q;
    lock_d     = lock_q;
    lock_gnt_d = lock_gnt_q;
    if (ac_hs) begin
      rr_d   = ~gnt;
      lock_d = 1'b0;
    end else if (ac_req) begin
      lock_d     = 1'b1;
      lock_gnt_d = gnt;
    end

    cr_mem_d  = cr_mem_q;
    cr_wptr_d = cr_wptr_q;
    cr_rptr_d = cr_rptr_q;
    cr_cnt_d  = cr_cnt_q;
    if (cr_push) begin
      cr_mem_d[cr_wptr_q] = gnt;
      cr_wptr_d           = cr_wptr_q + PtrW'(1);
    end
    if (cr_pop) begin
      cr_rptr_d = cr_rptr_q + PtrW'(1);
    end
    if (cr_push && !cr_pop) begin
      cr_cnt_d = cr_cnt_q + CntW'(1);
    end else if (!cr_push && cr_pop) begin
      cr_cnt_d = cr_cnt_q - CntW'(1);
    end

    cd_mem_d  = cd_mem_q;
    cd_wptr_d = cd_wptr_q;
    cd_rptr_d = cd_rptr_q;
    cd_cnt_d  = cd_cnt_q;
    if (cd_push) begin
      cd_mem_d[cd_wptr_q] = cr_head;
      cd_wptr_d           = cd_wptr_q + PtrW'(1);
    end
    if (cd_pop) begin
      cd_rptr_d = cd_rptr_q + PtrW'(1);
    end
    if (cd_push && !cd_pop) begin
      cd_cnt_d = cd_cnt_q + CntW'(1);
    end else if (!cd_push && cd_pop) begin
      cd_cnt_d = cd_cnt_q - CntW'(1);
    end
  end

  // State registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_q       <= 1'b0;
      lock_q     <= 1'b0;
      lock_gnt_q <= 1'b0;
      cr_mem_q   <= '0;
      cr_wptr_q  <= '0;
      cr_rptr_q  <= '0;
      cr_cnt_q   <= '0;
      cd_mem_q   <= '0;
      cd_wptr_q  <= '0;
      cd_rptr_q  <= '0;
      cd_cnt_q   <= '0;
    end else begin
      rr_q       <= rr_d;
      lock_q     <= lock_d;
      lock_gnt_q <= lock_gnt_d;
      cr_mem_q   <= cr_mem_d;
      cr_wptr_q  <= cr_wptr_d;
      cr_rptr_q  <= cr_rptr_d;
      cr_cnt_q   <= cr_cnt_d;
      cd_mem_q   <= cd_mem_d;
      cd_wptr_q  <= cd_wptr_d;
      cd_rptr_q  <= cd_rptr_d;
      cd_cnt_q   <= cd_cnt_d;
    end
  end

endmodule

// File: tb/tb_ccu_snoop_arbiter.sv
// tb/tb_ccu_snoop_arbiter.sv - directed self-checking bench for ccu_snoop_arbiter
module tb_ccu_snoop_arbiter;

  logic              clk_i = 1'b0;
  logic              rst_ni;
  logic [1:0]        slv_ac_valid_i;
  logic [1:0]        slv_ac_ready_o;
  logic [1:0][63:0]  slv_ac_addr_i;
  logic [1:0][3:0]   slv_ac_snoop_i;
  logic [1:0][2:0]   slv_ac_prot_i;
  logic [1:0][1:0]   slv_domain_i;
  logic [1:0]        slv_cr_valid_o;
  logic [1:0]        slv_cr_ready_i;
  logic [1:0][4:0]   slv_cr_resp_o;
  logic [1:0]        slv_cd_valid_o;
  logic [1:0]        slv_cd_ready_i;
  logic [1:0][63:0]  slv_cd_data_o;
  logic [1:0]        slv_cd_last_o;
  logic              mst_ac_valid_o;
  logic              mst_ac_ready_i;
  logic [63:0]       mst_ac_addr_o;
  logic [3:0]        mst_ac_snoop_o;
  logic [2:0]        mst_ac_prot_o;
  logic [1:0]        mst_domain_o;
  logic              mst_cr_valid_i;
  logic              mst_cr_ready_o;
  logic [4:0]        mst_cr_resp_i;
  logic              mst_cd_valid_i;
  logic              mst_cd_ready_o;
  logic [63:0]       mst_cd_data_i;
  logic              mst_cd_last_i;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk_i = ~clk_i;

  ccu_snoop_arbiter #(.AddrWidth(64), .DataWidth(64), .MaxTrans(4)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .slv_ac_valid_i(slv_ac_valid_i), .slv_ac_ready_o(slv_ac_ready_o),
    .slv_ac_addr_i(slv_ac_addr_i), .slv_ac_snoop_i(slv_ac_snoop_i),
    .slv_ac_prot_i(slv_ac_prot_i), .slv_domain_i(slv_domain_i),
    .slv_cr_valid_o(slv_cr_valid_o), .slv_cr_ready_i(slv_cr_ready_i),
    .slv_cr_resp_o(slv_cr_resp_o),
    .slv_cd_valid_o(slv_cd_valid_o), .slv_cd_ready_i(slv_cd_ready_i),
    .slv_cd_data_o(slv_cd_data_o), .slv_cd_last_o(slv_cd_last_o),
    .mst_ac_valid_o(mst_ac_valid_o), .mst_ac_ready_i(mst_ac_ready_i),
    .mst_ac_addr_o(mst_ac_addr_o), .mst_ac_snoop_o(mst_ac_snoop_o),
    .mst_ac_prot_o(mst_ac_prot_o), .mst_domain_o(mst_domain_o),
    .mst_cr_valid_i(mst_cr_valid_i), .mst_cr_ready_o(mst_cr_ready_o),
    .mst_cr_resp_i(mst_cr_resp_i),
    .mst_cd_valid_i(mst_cd_valid_i), .mst_cd_ready_o(mst_cd_ready_o),
    .mst_cd_data_i(mst_cd_data_i), .mst_cd_last_i(mst_cd_last_i)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic reset_pulse();
    rst_ni = 1'b0;
    tick();
    rst_ni = 1'b1;
    #1;
  endtask

  initial begin
    rst_ni         = 1'b0;
    slv_ac_valid_i = 2'b11;
    slv_ac_addr_i[0] = 64'h1000;
    slv_ac_addr_i[1] = 64'h2000;
    slv_ac_snoop_i[0] = 4'h7;
    slv_ac_snoop_i[1] = 4'h1;
    slv_ac_prot_i[0]  = 3'h2;
    slv_ac_prot_i[1]  = 3'h5;
    slv_domain_i[0]   = 2'h1;
    slv_domain_i[1]   = 2'h2;
    slv_cr_ready_i = 2'b11;
    slv_cd_ready_i = 2'b11;
    mst_ac_ready_i = 1'b1;
    mst_cr_valid_i = 1'b1;
    mst_cr_resp_i  = 5'h01;
    mst_cd_valid_i = 1'b1;
    mst_cd_data_i  = 64'hdead;
    mst_cd_last_i  = 1'b0;

    // Reset: everything quiet even with live inputs
    tick();
    tick();
    chk("rst_ac_valid", 64'(mst_ac_valid_o), 64'h0);
    chk("rst_ac_ready", 64'(slv_ac_ready_o), 64'h0);
    chk("rst_cr_ready", 64'(mst_cr_ready_o), 64'h0);
    chk("rst_cd_ready", 64'(mst_cd_ready_o), 64'h0);
    chk("rst_ac_addr", mst_ac_addr_o, 64'h0);
    slv_ac_valid_i = 2'b00;
    mst_cr_valid_i = 1'b0;
    mst_cd_valid_i = 1'b0;
    rst_ni = 1'b1;
    #1;
    chk("idle_cr_valid", 64'(slv_cr_valid_o), 64'h0);

    // Single write-path snoop
    slv_ac_valid_i = 2'b01;
    #1;
    chk("t1_ac_valid", 64'(mst_ac_valid_o), 64'h1);
    chk("t1_ac_addr", mst_ac_addr_o, 64'h1000);
    chk("t1_ac_snoop", 64'(mst_ac_snoop_o), 64'h7);
    chk("t1_ac_prot", 64'(mst_ac_prot_o), 64'h2);
    chk("t1_domain", 64'(mst_domain_o), 64'h1);
    chk("t1_ac_ready", 64'(slv_ac_ready_o), 64'h1);
    tick();
    slv_ac_valid_i = 2'b00;
    mst_cr_valid_i = 1'b1;
    mst_cr_resp_i  = 5'h01;
    #1;
    chk("t1_cr_valid", 64'(slv_cr_valid_o), 64'h1);
    chk("t1_cr_ready", 64'(mst_cr_ready_o), 64'h1);
    chk("t1_cr_resp", 64'(slv_cr_resp_o[0]), 64'h1);
    tick();
    mst_cr_valid_i = 1'b0;
    for (int b = 0; b < 4; b++) begin
      mst_cd_valid_i = 1'b1;
      mst_cd_data_i  = 64'hA0 + 64'(b);
      mst_cd_last_i  = (b == 3);
      #1;
      chk("t1_cd_valid", 64'(slv_cd_valid_o), 64'h1);
      chk("t1_cd_ready", 64'(mst_cd_ready_o), 64'h1);
      chk("t1_cd_data", slv_cd_data_o[0], 64'hA0 + 64'(b));
      tick();
    end
    #1;
    chk("t1_cd_popped", 64'(mst_cd_ready_o), 64'h0);
    chk("t1_cd_valid_off", 64'(slv_cd_valid_o), 64'h0);
    mst_cd_valid_i = 1'b0;
    mst_cd_last_i  = 1'b0;

    // Round-robin from reset
    reset_pulse();
    slv_ac_valid_i = 2'b11;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("t2_gnt", 64'(slv_ac_ready_o), (i % 2 == 0) ? 64'h1 : 64'h2);
      chk("t2_addr", mst_ac_addr_o, (i % 2 == 0) ? 64'h1000 : 64'h2000);
      tick();
    end
    slv_ac_valid_i = 2'b00;
    mst_cr_valid_i = 1'b1;
    mst_cr_resp_i  = 5'h00;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("t2_cr_route", 64'(slv_cr_valid_o), (i % 2 == 0) ? 64'h1 : 64'h2);
      tick();
    end
    #1;
    chk("t2_cr_empty", 64'(mst_cr_ready_o), 64'h0);
    mst_cr_valid_i = 1'b0;

    // Lock: rr is 0 here; one write-path handshake moves it to 1 first
    slv_ac_valid_i = 2'b01;
    tick();
    mst_ac_ready_i = 1'b0;
    #1;
    chk("t3_ac_ready_low", 64'(slv_ac_ready_o), 64'h0);
    chk("t3_ac_valid", 64'(mst_ac_valid_o), 64'h1);
    tick();
    slv_ac_valid_i = 2'b11;
    for (int i = 0; i < 2; i++) begin
      #1;
      chk("t3_addr_held", mst_ac_addr_o, 64'h1000);
      tick();
    end
    mst_ac_ready_i = 1'b1;
    #1;
    chk("t3_gnt_kept", 64'(slv_ac_ready_o), 64'h1);
    tick();
    #1;
    chk("t3_gnt_next", 64'(slv_ac_ready_o), 64'h2);
    tick();
    slv_ac_valid_i = 2'b00;
    mst_cr_valid_i = 1'b1;
    mst_cr_resp_i  = 5'h00;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("t3_cr_route", 64'(slv_cr_valid_o), (i < 2) ? 64'h1 : 64'h2);
      tick();
    end
    mst_cr_valid_i = 1'b0;

    // CR owner FIFO full
    reset_pulse();
    slv_ac_valid_i = 2'b01;
    for (int i = 0; i < 4; i++) tick();
    #1;
    chk("t4_full_valid", 64'(mst_ac_valid_o), 64'h0);
    chk("t4_full_ready", 64'(slv_ac_ready_o), 64'h0);
    mst_cr_valid_i = 1'b1;
    mst_cr_resp_i  = 5'h00;
    #1;
    chk("t4_pop_ready", 64'(mst_cr_ready_o), 64'h1);
    chk("t4_full_during_pop", 64'(mst_ac_valid_o), 64'h0);
    tick();
    mst_cr_valid_i = 1'b0;
    #1;
    chk("t4_slot_free", 64'(slv_ac_ready_o), 64'h1);
    tick();
    slv_ac_valid_i = 2'b00;

    // Fill the CD owner FIFO, then a DataTransfer CR must stall
    mst_cr_valid_i = 1'b1;
    mst_cr_resp_i  = 5'h01;
    for (int i = 0; i < 4; i++) tick();
    mst_cr_valid_i = 1'b0;
    slv_ac_valid_i = 2'b01;
    tick();
    slv_ac_valid_i = 2'b00;
    mst_cr_valid_i = 1'b1;
    mst_cr_resp_i  = 5'h01;
    #1;
    chk("t5_cr_stall", 64'(mst_cr_ready_o), 64'h0);
    chk("t5_cr_valid_gated", 64'(slv_cr_valid_o), 64'h0);
    tick();
    chk("t5_cr_stall2", 64'(mst_cr_ready_o), 64'h0);
    mst_cd_valid_i = 1'b1;
    mst_cd_last_i  = 1'b1;
    mst_cd_data_i  = 64'h55;
    #1;
    chk("t5_cd_ready", 64'(mst_cd_ready_o), 64'h1);
    chk("t5_cd_route", 64'(slv_cd_valid_o), 64'h1);
    chk("t5_cr_still", 64'(mst_cr_ready_o), 64'h0);
    tick();
    mst_cd_valid_i = 1'b0;
    mst_cd_last_i  = 1'b0;
    #1;
    chk("t5_cr_released", 64'(mst_cr_ready_o), 64'h1);
    chk("t5_cr_route", 64'(slv_cr_valid_o), 64'h1);
    tick();
    mst_cr_valid_i = 1'b0;

    // Reset in the middle of a CD burst
    mst_cd_valid_i = 1'b1;
    mst_cd_data_i  = 64'h77;
    #1;
    chk("t6_cd_live", 64'(mst_cd_ready_o), 64'h1);
    slv_ac_valid_i = 2'b11;
    mst_ac_ready_i = 1'b1;
    rst_ni = 1'b0;
    #1;
    chk("t6_cd_ready", 64'(mst_cd_ready_o), 64'h0);
    chk("t6_cd_valid", 64'(slv_cd_valid_o), 64'h0);
    chk("t6_ac_valid", 64'(mst_ac_valid_o), 64'h0);
    chk("t6_ac_ready", 64'(slv_ac_ready_o), 64'h0);
    tick();
    tick();
    rst_ni = 1'b1;
    mst_cd_valid_i = 1'b0;
    #1;
    chk("t6_first_gnt", 64'(slv_ac_ready_o), 64'h1);
    chk("t6_first_addr", mst_ac_addr_o, 64'h1000);
    chk("t6_cd_empty", 64'(mst_cd_ready_o), 64'h0);
    tick();
    slv_ac_valid_i = 2'b00;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1, "timeout");
  end

endmodule
